// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3 slave modelling on-chip SRAM. It has independent read and write
//   engines, and each engine handles one burst at a time. The array is
//   word-organised (32-bit) and writes honour byte strobes.
//
// Parameters
//   MEM_WORDS     array depth in 32-bit words (power of two)
//   READ_LATENCY  cycles from the AR handshake edge to the first rvalid (>=1)
//
// Ports
//   i_clk, i_rst                     clock, synchronous active-high reset
//   ar* / arvalid / arready          read address channel
//   rid/rdata/rresp/rlast/rvalid/rready  read data channel
//   aw* / awvalid / awready          write address channel
//   wid/wdata/wstrb/wlast/wvalid/wready  write data channel
//   bid/bresp/bvalid/bready          write response channel
//   arlock/arcache/arprot, awlock/awcache/awprot and wid are ignored.
//
// Optional feature
//   AXI_SRAM_WRAP_BURST_EN  when defined, burst 2'b10 wraps inside a window
//                           of (len+1)<<size bytes. Only len 1/3/7/15 are
//                           legal; any other len gives SLVERR and the
//                           address advances as INCR. When undefined,
//                           WRAP behaves as INCR with an OKAY response.
module axi_sram_slave #(
   parameter int MEM_WORDS    = 16384,
   parameter int READ_LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

   logic [31:0] mem [MEM_WORDS];

   logic unused;
   assign unused = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid};

   // The wrap mask is all ones for non-wrapping bursts. That reduces the
   // wrap formula below to a plain increment.
   function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] size,
                                             input logic fixed, input logic [31:0] mask);
      logic [31:0] nxt;
      nxt = (a & ~mask) | ((a + (32'd1 << size)) & mask);
      return fixed ? a : nxt;
   endfunction

   // Decode the burst attributes at the address handshake.
   logic        ar_err, aw_err;
   logic [31:0] ar_mask, aw_mask;
   always_comb begin
      ar_err  = arsize > 3'd2;
      aw_err  = awsize > 3'd2;
      ar_mask = '1;
      aw_mask = '1;
`ifdef AXI_SRAM_WRAP_BURST_EN
      if (arburst == 2'b10) begin
         if (arlen inside {8'd1, 8'd3, 8'd7, 8'd15})
            ar_mask = ((32'(arlen) + 32'd1) << arsize) - 32'd1;
         else
            ar_err = 1'b1;
      end
      if (awburst == 2'b10) begin
         if (awlen inside {8'd1, 8'd3, 8'd7, 8'd15})
            aw_mask = ((32'(awlen) + 32'd1) << awsize) - 32'd1;
         else
            aw_err = 1'b1;
      end
`endif
   end

   // ---------------- read engine ----------------
   rstate_t     r_state;
   logic [LW-1:0] r_cnt;
   logic [31:0] r_addr, r_mask, r_next;
   logic [7:0]  r_len, r_beat;
   logic [2:0]  r_size;
   logic        r_fixed, r_err;

   assign r_next = step_addr(r_addr, r_size, r_fixed, r_mask);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= R_IDLE;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rdata   <= '0;
         rresp   <= '0;
         rid     <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_mask  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_size  <= '0;
         r_fixed <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               arready <= 1'b1;
               if (arvalid && arready) begin
                  arready <= 1'b0;
                  rid     <= arid;
                  r_addr  <= araddr;
                  r_len   <= arlen;
                  r_size  <= arsize;
                  r_fixed <= (arburst == 2'b00);
                  r_mask  <= ar_mask;
                  r_err   <= ar_err;
                  r_cnt   <= LW'(READ_LATENCY - 1);
                  r_state <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (r_cnt == '0) begin
                  rvalid  <= 1'b1;
                  rdata   <= r_err ? 32'd0 : mem[r_addr[AW+1:2]];
                  rresp   <= r_err ? 2'b10 : 2'b00;
                  rlast   <= (r_len == 8'd0);
                  r_beat  <= 8'd0;
                  r_state <= R_DATA;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     arready <= 1'b1;
                     r_state <= R_IDLE;
                  end else begin
                     // The next beat is registered on the same edge, so
                     // there is no bubble between beats.
                     r_addr <= r_next;
                     rdata  <= r_err ? 32'd0 : mem[r_next[AW+1:2]];
                     r_beat <= r_beat + 8'd1;
                     rlast  <= (r_beat + 8'd1 == r_len);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- write engine ----------------
   wstate_t     w_state;
   logic [31:0] w_addr, w_mask;
   logic [7:0]  w_len, w_beat;
   logic [2:0]  w_size;
   logic        w_fixed, w_err, w_final;

   assign w_final = (w_beat == w_len);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         w_state <= W_IDLE;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= '0;
         bid     <= '0;
         w_addr  <= '0;
         w_mask  <= '0;
         w_len   <= '0;
         w_beat  <= '0;
         w_size  <= '0;
         w_fixed <= 1'b0;
         w_err   <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               awready <= 1'b1;
               if (awvalid && awready) begin
                  awready <= 1'b0;
                  wready  <= 1'b1;
                  bid     <= awid;
                  w_addr  <= awaddr;
                  w_len   <= awlen;
                  w_size  <= awsize;
                  w_fixed <= (awburst == 2'b00);
                  w_mask  <= aw_mask;
                  w_err   <= aw_err;
                  w_beat  <= 8'd0;
                  w_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (wvalid) begin
                  // The burst ends on the beat count. A wlast that is early
                  // or missing only poisons the response.
                  w_addr <= step_addr(w_addr, w_size, w_fixed, w_mask);
                  w_beat <= w_beat + 8'd1;
                  w_err  <= w_err | (wlast != w_final);
                  if (w_final) begin
                     wready  <= 1'b0;
                     bvalid  <= 1'b1;
                     bresp   <= (w_err || (wlast != w_final)) ? 2'b10 : 2'b00;
                     w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // The array is never reset. A read registered on the same edge as this
   // write sees the old word.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_state == W_DATA && wvalid) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int checks = 0;
   int errors = 0;

   logic [31:0] data_q [256];
   logic [1:0]  resp_q [256];
   logic [31:0] last_mask;
   logic [3:0]  got_rid;
   int          nbeats, lat;
   logic [1:0]  wresp;
   logic [3:0]  wbid;

   axi_sram_slave dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [31:0] d0,
                           input logic [3:0] strb, input int last_at);
      int n;
      awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 50) begin tick; n++; end
      tick;
      awvalid = 1'b0;
      chk("wready_after_aw", {31'd0, wready}, 32'd1);
      for (int i = 0; i <= int'(len); i++) begin
         wdata = d0 + i; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
         n = 0;
         while (!wready && n < 50) begin tick; n++; end
         tick;
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("bvalid_after_last_w", {31'd0, bvalid}, 32'd1);
      wresp = bresp; wbid = bid;
      bready = 1'b1;
      tick;
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int stall_beat, input int stall_n);
      int n, guard;
      bit stalled;
      logic [31:0] hold;
      araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin tick; n++; end
      tick;
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 20) begin tick; lat++; end
      rready = 1'b1; nbeats = 0; guard = 0; last_mask = '0; stalled = 0;
      while (nbeats <= int'(len) && guard < 600) begin
         if (nbeats == stall_beat && stall_n > 0 && !stalled) begin
            rready = 1'b0;
            hold = rdata;
            for (int k = 0; k < stall_n; k++) begin
               tick;
               chk("stall_rvalid_held", {31'd0, rvalid}, 32'd1);
               chk("stall_rdata_held", rdata, hold);
            end
            rready = 1'b1;
            stalled = 1;
         end
         if (rvalid) begin
            data_q[nbeats] = rdata;
            resp_q[nbeats] = rresp;
            if (rlast && nbeats < 32) last_mask[nbeats] = 1'b1;
            got_rid = rid;
            nbeats++;
         end
         tick;
         guard++;
      end
      rready = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0;
      arprot = '0; arvalid = 1'b0; rready = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0;
      awprot = '0; awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0;

      // reset state
      tick; tick; tick;
      chk("rst_handshake_outs", {26'd0, arready, awready, wready, rvalid, rlast, bvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ids_resps", {20'd0, rid, rresp, bid, bresp}, 32'd0);
      i_rst = 1'b0;
      chk("first_cycle_after_rst", {30'd0, arready, awready}, 32'd0);
      tick;
      chk("ready_after_release", {30'd0, arready, awready}, 32'd3);

      // 16-beat INCR write then read
      do_write(32'h1000, 8'd15, 3'd2, 2'b01, 4'd3, 32'd0, 4'hF, 15);
      chk("wr16_bresp", {30'd0, wresp}, 32'd0);
      chk("wr16_bid", {28'd0, wbid}, 32'd3);
      do_read(32'h1000, 8'd15, 3'd2, 2'b01, 4'd5, -1, 0);
      chk("rd16_latency", lat, 32'd2);
      chk("rd16_nbeats", nbeats, 32'd16);
      chk("rd16_rid", {28'd0, got_rid}, 32'd5);
      chk("rd16_rlast_mask", last_mask, 32'h0000_8000);
      for (int i = 0; i < 16; i++) chk($sformatf("rd16_data%0d", i), data_q[i], i);
      chk("rd16_resp0", {30'd0, resp_q[0]}, 32'd0);

      // byte strobes
      do_write(32'h2000, 8'd0, 3'd2, 2'b01, 4'd1, 32'hAABBCCDD, 4'hF, 0);
      do_write(32'h2000, 8'd0, 3'd2, 2'b01, 4'd1, 32'h11223344, 4'b0101, 0);
      do_read(32'h2000, 8'd0, 3'd2, 2'b01, 4'd2, -1, 0);
      chk("strobe_merge", data_q[0], 32'hAA22CC44);
      chk("single_rlast", last_mask, 32'h1);

      // backpressure on beat 5
      do_read(32'h1000, 8'd15, 3'd2, 2'b01, 4'd6, 5, 3);
      chk("stall_nbeats", nbeats, 32'd16);
      for (int i = 0; i < 16; i++) chk($sformatf("stall_data%0d", i), data_q[i], i);
      chk("stall_rlast_mask", last_mask, 32'h0000_8000);

      // WRAP burst, len 3, starting at 0x1008
      do_read(32'h1008, 8'd3, 3'd2, 2'b10, 4'd7, -1, 0);
`ifdef AXI_SRAM_WRAP_BURST_EN
      chk("wrap_d0", data_q[0], 32'd2);
      chk("wrap_d1", data_q[1], 32'd3);
      chk("wrap_d2", data_q[2], 32'd0);
      chk("wrap_d3", data_q[3], 32'd1);
`else
      chk("wrap_d0", data_q[0], 32'd2);
      chk("wrap_d1", data_q[1], 32'd3);
      chk("wrap_d2", data_q[2], 32'd4);
      chk("wrap_d3", data_q[3], 32'd5);
`endif
      chk("wrap_resp", {30'd0, resp_q[3]}, 32'd0);

      // reset in the middle of concurrent bursts
      araddr = 32'h1000; arlen = 8'd15; arsize = 3'd2; arburst = 2'b01; arid = 4'd1; arvalid = 1'b1;
      awaddr = 32'h3000; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awid = 4'd2; awvalid = 1'b1;
      tick;
      arvalid = 1'b0; awvalid = 1'b0;
      tick;
      wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wlast = 1'b0; rready = 1'b1;
      tick; tick; tick;
      chk("mid_burst_rvalid", {31'd0, rvalid}, 32'd1);
      chk("mid_burst_wready", {31'd0, wready}, 32'd1);
      i_rst = 1'b1;
      tick;
      chk("abort_valids", {29'd0, rvalid, bvalid, wready}, 32'd0);
      i_rst = 1'b0; wvalid = 1'b0; rready = 1'b0;
      tick;
      chk("abort_ready_back", {30'd0, arready, awready}, 32'd3);
      do_read(32'h1000, 8'd3, 3'd2, 2'b01, 4'd4, -1, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("post_rst_data%0d", i), data_q[i], i);
      do_read(32'h2000, 8'd0, 3'd2, 2'b01, 4'd4, -1, 0);
      chk("post_rst_strobe_word", data_q[0], 32'hAA22CC44);

      // oversize read -> SLVERR with zero data, beat count unchanged
      do_read(32'h1000, 8'd1, 3'd3, 2'b01, 4'd8, -1, 0);
      chk("slverr_nbeats", nbeats, 32'd2);
      chk("slverr_resp0", {30'd0, resp_q[0]}, 32'd2);
      chk("slverr_resp1", {30'd0, resp_q[1]}, 32'd2);
      chk("slverr_data0", data_q[0], 32'd0);
      chk("slverr_data1", data_q[1], 32'd0);
      chk("slverr_rlast", last_mask, 32'h2);

      // early wlast -> 4 beats still accepted, SLVERR, data written
      do_write(32'h4000, 8'd3, 3'd2, 2'b01, 4'd7, 32'h100, 4'hF, 1);
      chk("early_wlast_bresp", {30'd0, wresp}, 32'd2);
      chk("early_wlast_bid", {28'd0, wbid}, 32'd7);
      do_read(32'h4000, 8'd3, 3'd2, 2'b01, 4'd9, -1, 0);
      for (int i = 0; i < 4; i++) chk($sformatf("early_wlast_data%0d", i), data_q[i], 32'h100 + i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
